// File: rtl/handball_pkg.sv
// rtl/handball_pkg.sv - shared constants for the Handball input conditioner
//
// Purpose: debounce lengths for simulation and board builds, with the
// matching counter widths and a parameter sanity helper.
// Ports: none (package).
package handball_pkg;

  // Simulation build: short debounce so benches stay fast.
  localparam int DEBOUNCE_CYCLES_SIM   = 8;
  localparam int CNT_W_SIM             = 4;

  // Board build: 100000 cycles at 5 MHz is 20 ms; 2**17 = 131072 covers it.
  localparam int DEBOUNCE_CYCLES_BOARD = 100000;
  localparam int CNT_W_BOARD           = 17;

  // True when a debounce length fits a counter of the given width.
  function automatic bit debounce_fits(input int cycles, input int cnt_w);
    return (cycles >= 2) && (cycles < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/handball_input_conditioner_if.sv
// rtl/handball_input_conditioner_if.sv - board-pin and Handball-side signal bundle
//
// Purpose: groups the raw player inputs and the conditioned outputs.
// Signals:
//   BTN_RAW    raw push button, active-high, asynchronous, bouncing
//   START_RAW  raw START switch, active-high, asynchronous, bouncing
//   PULSER     one-cycle pulse per debounced button press
//   START      debounced START level
//   BTN_LEVEL  debounced button level
// Modports: master drives the raw inputs, slave is the conditioner.
interface handball_input_conditioner_if;

  logic BTN_RAW;
  logic START_RAW;
  logic PULSER;
  logic START;
  logic BTN_LEVEL;

  modport master (
    output BTN_RAW,
    output START_RAW,
    input  PULSER,
    input  START,
    input  BTN_LEVEL
  );

  modport slave (
    input  BTN_RAW,
    input  START_RAW,
    output PULSER,
    output START,
    output BTN_LEVEL
  );

endinterface

// File: rtl/handball_input_conditioner_debounce_channel.sv
// rtl/handball_input_conditioner_debounce_channel.sv - synchroniser plus counting debouncer
//
// Purpose: brings one asynchronous bouncing input into CLKK and only changes
// the debounced level after the synchronised input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   CLKK     system clock
//   RESET_N  asynchronous active-low reset
//   raw      asynchronous raw input
//   level    debounced level
module debounce_channel
  import handball_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int CNT_W           = CNT_W_SIM
) (
  input  logic CLKK,
  input  logic RESET_N,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Any cycle where sync2 agrees with stable restarts the count, so a single
  // bounce throws away all progress. The flip clears cnt, so it never wraps.
  always_ff @(posedge CLKK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/handball_input_conditioner.sv
// rtl/handball_input_conditioner.sv - button/START front end feeding Handball
//
// Purpose: debounces the player button and START switch and turns each
// debounced button press into a single-cycle PULSER.
// Ports:
//   CLKK     system clock
//   RESET_N  asynchronous active-low reset
//   io       slave side of handball_input_conditioner_if
//            (BTN_RAW, START_RAW in; PULSER, START, BTN_LEVEL out)
module handball_input_conditioner
  import handball_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int CNT_W           = CNT_W_SIM
) (
  input  logic                         CLKK,
  input  logic                         RESET_N,
  handball_input_conditioner_if.slave  io
);

  logic btn_level;
  logic btn_level_d;
  logic start_level;
  logic pulser;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn (
    .CLKK    (CLKK),
    .RESET_N (RESET_N),
    .raw     (io.BTN_RAW),
    .level   (btn_level)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_start (
    .CLKK    (CLKK),
    .RESET_N (RESET_N),
    .raw     (io.START_RAW),
    .level   (start_level)
  );

  // Rising-edge detect on the debounced level; releases never pulse and a
  // held button yields one pulse because btn_level_d catches up next cycle.
  always_ff @(posedge CLKK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_level_d <= 1'b0;
      pulser      <= 1'b0;
    end else begin
      btn_level_d <= btn_level;
      pulser      <= btn_level & ~btn_level_d;
    end
  end

  assign io.PULSER    = pulser;
  assign io.START     = start_level;
  assign io.BTN_LEVEL = btn_level;

endmodule
